aes_key_schedule: RTL and testbench
===================================

Name: aes_key_schedule

Overview:
Iterative AES-128 key scheduler that sits directly downstream of the key input and feeds the encryption round datapath.
- Accepts a 128-bit cipher key through a valid/ready handshake.
- Generates all 11 round keys, one round per 5 cycles, using a single byte-serial S-box for SubWord.
- Stores the keys in an internal round-key file that the cipher datapath reads by round index, with 1-cycle read latency.

Parameters:
NR, 10, number of rounds; round-key file depth is NR+1.
KEY_W, 128, key and round-key width; only 128 is supported.

Ports:
clk  in  1  clock
rst  in  1  reset
key_valid  in  1  key_in is valid
key_in  in  128  cipher key; [127:96]=w0, [95:64]=w1, [63:32]=w2, [31:0]=w3
key_ready  out  1  scheduler can accept a key (IDLE or DONE)
busy  out  1  expansion in progress
sched_done  out  1  all NR+1 round keys are valid
rk_addr  in  4  round-key read index, 0..NR
rk_data  out  128  registered round key for rk_addr
rk_valid  out  1  registered; rk_data holds an already-generated key

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk.
  - Reset values: state=IDLE, key file all 0, key_ready=1, busy=0, sched_done=0, rk_data=0, rk_valid=0, round counter=0, rcon=8'h01.
  - Reset mid-expansion aborts the expansion and clears all of the above.
- States:
  - IDLE: key_ready=1. On key_valid&&key_ready, write rk[0]=key_in, load the working key, set round=1, rcon=01, byte_idx=0, go to SUB.
  - SUB, 4 cycles:
    - Byte order: byte_idx 0..3 selects a byte of RotWord(w3) = {w3[23:16], w3[15:8], w3[7:0], w3[31:24]}, MSB byte first.
    - Each selected byte drives the combinational S-box; the result is captured into temp_word[31-8*byte_idx -: 8].
    - After byte_idx=3, go to MIX.
  - MIX, 1 cycle:
    - g = temp_word ^ {rcon, 24'h0}.
    - w4=w0^g, w5=w1^w4, w6=w2^w5, w7=w3^w6.
    - Write rk[round]={w4,w5,w6,w7} and update the working key.
    - rcon <= xtime(rcon), i.e. (rcon<<1) ^ (rcon[7] ? 8'h1B : 0). Sequence: 01,02,04,08,10,20,40,80,1B,36.
    - If round==NR go to DONE, else round++ and go to SUB.
  - DONE: sched_done=1, key_ready=1, busy=0. The key file holds its contents until a new key is accepted.
- Timing: with the handshake on edge E0, rk[r] is written on edge E0+5r. After edge E0+50, sched_done=1 and busy=0. busy=1 from the edge after E0 through E0+50.
- Re-key in DONE: accepted exactly as in IDLE. sched_done clears on the same edge and the written-key count resets to 1. Stale rk[1..10] read with rk_valid=0.
- key_valid while busy is ignored; key_ready=0 during SUB and MIX.
- Read port, registered every cycle:
  - rk_data <= (rk_addr<=NR) ? rk[rk_addr] : 0.
  - rk_valid <= rk_addr < keys_written.
  - Read and write of the same index on the same edge returns the old contents with rk_valid=0.
- Arithmetic: pure XOR on 32-bit words. The round counter is 4 bits and never exceeds NR.

Decomposition:
- Package aes_pkg holds:
  - NR, NK=4
  - typedef word_t (logic [31:0]) and rkey_t (logic [127:0])
  - state enum {IDLE, SUB, MIX, DONE}
  - function xtime(byte)
- Sub-module: one instance of the existing combinational s_box (8-bit in/out). The key file and FSM stay in this module.

Test Plan:
- Expansion vector: key 2b7e151628aed2a6abf7158809cf4f3c.
  - rk[1]=a0fafe1788542cb123a339392a6c7605.
  - rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - sched_done rises exactly 50 cycles after the handshake.
- Handshake: assert key_valid continuously with changing key_in during expansion -> only the first key is accepted and key_ready=0 for 50 cycles. Also read rk_addr=1 at E0+3 -> rk_valid=0.
- Rcon wrap: check rcon at rounds 8, 9, 10 -> 80, 1B, 36.
- Re-key in DONE with key 000102030405060708090a0b0c0d0e0f -> sched_done drops next cycle; rk[10]=13111d7fe3944a17f307a78b4d2b30c5 after 50 cycles.
- Async reset pulse at cycle 20 of expansion -> all outputs return to reset values immediately. A following key expands correctly.
- Read port: rk_addr=11..15 -> rk_data=0, rk_valid=0. rk_addr=0 immediately after the handshake -> key_in with rk_valid=1 one cycle later.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared types, constants and helpers for the AES-128 key
//                scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int NR = 10;
    localparam int NK = 4;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] rkey_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        MIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/s_box.sv
`default_nettype none
// ============================================================================
//  Module      : s_box
//  Description : Combinational AES forward S-box, one byte in, one byte out.
//  Revision    : 1.0 - initial release
// ============================================================================
module s_box (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Row-major table, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = c_SBOX[i_byte];

endmodule
`default_nettype wire

// File: rtl/aes_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_schedule
//  Description : Iterative AES-128 key expansion. One round key every five
//                cycles (four byte-serial S-box lookups plus one XOR cycle),
//                stored in an 11-entry round-key file with a registered
//                read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int NR    = 10,
    parameter int KEY_W = 128      // only 128 is meaningful
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_in,
    output logic             key_ready,
    output logic             busy,
    output logic             sched_done,
    input  logic [3:0]       rk_addr,
    output logic [KEY_W-1:0] rk_data,
    output logic             rk_valid
);

    localparam logic [3:0] c_NR_IDX = 4'(NR);

    state_t     r_state;
    logic [1:0] r_byte_idx;
    logic [3:0] r_round;
    logic [7:0] r_rcon;
    logic [3:0] r_keys_written;
    word_t      r_temp;
    rkey_t      r_wkey;
    rkey_t      r_rk [0:NR];

    word_t      w_w0, w_w1, w_w2, w_w3;
    word_t      w_rot;
    word_t      w_g;
    word_t      w_w4, w_w5, w_w6, w_w7;
    word_t      w_temp_next;
    logic [7:0] w_sbox_in;
    logic [7:0] w_sbox_out;

    assign w_w0  = r_wkey[127:96];
    assign w_w1  = r_wkey[95:64];
    assign w_w2  = r_wkey[63:32];
    assign w_w3  = r_wkey[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    // Pick the RotWord byte for the current SubWord step, MSB byte first.
    always_comb begin
        w_sbox_in = w_rot[31:24];
        case (r_byte_idx)
            2'd0:    w_sbox_in = w_rot[31:24];
            2'd1:    w_sbox_in = w_rot[23:16];
            2'd2:    w_sbox_in = w_rot[15:8];
            default: w_sbox_in = w_rot[7:0];
        endcase
    end

    s_box u_s_box (
        .i_byte (w_sbox_in),
        .o_byte (w_sbox_out)
    );

    // Merge the substituted byte into its lane of the temp word.
    always_comb begin
        w_temp_next = r_temp;
        case (r_byte_idx)
            2'd0:    w_temp_next[31:24] = w_sbox_out;
            2'd1:    w_temp_next[23:16] = w_sbox_out;
            2'd2:    w_temp_next[15:8]  = w_sbox_out;
            default: w_temp_next[7:0]   = w_sbox_out;
        endcase
    end

    assign w_g  = r_temp ^ {r_rcon, 24'h0};
    assign w_w4 = w_w0 ^ w_g;
    assign w_w5 = w_w1 ^ w_w4;
    assign w_w6 = w_w2 ^ w_w5;
    assign w_w7 = w_w3 ^ w_w6;

    // Control FSM, working key and round-key file writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_byte_idx     <= 2'd0;
            r_round        <= 4'd0;
            r_rcon         <= 8'h01;
            r_keys_written <= 4'd0;
            r_temp         <= '0;
            r_wkey         <= '0;
            key_ready      <= 1'b1;
            busy           <= 1'b0;
            sched_done     <= 1'b0;
            for (int i = 0; i <= NR; i++) begin
                r_rk[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (key_valid && key_ready) begin
                        r_rk[0]        <= key_in;
                        r_wkey         <= key_in;
                        r_round        <= 4'd1;
                        r_rcon         <= 8'h01;
                        r_byte_idx     <= 2'd0;
                        r_keys_written <= 4'd1;
                        key_ready      <= 1'b0;
                        busy           <= 1'b1;
                        sched_done     <= 1'b0;
                        r_state        <= SUB;
                    end
                end
                SUB: begin
                    r_temp     <= w_temp_next;
                    r_byte_idx <= r_byte_idx + 2'd1;
                    if (r_byte_idx == 2'd3) begin
                        r_state <= MIX;
                    end
                end
                MIX: begin
                    r_rk[r_round]  <= {w_w4, w_w5, w_w6, w_w7};
                    r_wkey         <= {w_w4, w_w5, w_w6, w_w7};
                    r_rcon         <= xtime(r_rcon);
                    r_keys_written <= r_keys_written + 4'd1;
                    if (r_round == c_NR_IDX) begin
                        r_state    <= DONE;
                        key_ready  <= 1'b1;
                        busy       <= 1'b0;
                        sched_done <= 1'b1;
                    end else begin
                        r_round <= r_round + 4'd1;
                        r_state <= SUB;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Registered read port; a same-edge write is not visible until next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_data  <= '0;
            rk_valid <= 1'b0;
        end else begin
            rk_data  <= (rk_addr <= c_NR_IDX) ? r_rk[rk_addr] : '0;
            rk_valid <= (rk_addr < r_keys_written);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_key_schedule
//  Description : Self-checking bench for aes_key_schedule with a FIPS-197
//                style word-array reference and an algebraic S-box.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_schedule;

    logic         clk;
    logic         rst;
    logic         key_valid;
    logic [127:0] key_in;
    logic         key_ready;
    logic         busy;
    logic         sched_done;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic         rk_valid;

    int total = 0;
    int bad   = 0;

    logic [127:0] exp_rk [0:10];

    localparam logic [127:0] c_K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_K1_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_K1_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_K2    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_K2_RA = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    aes_key_schedule #(.NR(10), .KEY_W(128)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .busy       (busy),
        .sched_done (sched_done),
        .rk_addr    (rk_addr),
        .rk_data    (rk_data),
        .rk_valid   (rk_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GF(2^8) product, AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0]  inv;
        logic [7:0]  s;
        logic [15:0] d;
        inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, x);
        end
        s = inv ^ 8'h63;
        for (int n = 1; n <= 4; n++) begin
            d = {inv, inv} << n;
            s = s ^ d[15:8];
        end
        return s;
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]),
                     sbox_ref(t[15:8]),  sbox_ref(t[7:0])};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input logic [3:0] a, input logic [127:0] exp_d,
                              input logic exp_v, input string tag);
        rk_addr = a;
        tick();
        check($sformatf("%s_data[%0d]", tag, a), rk_data, exp_d);
        check($sformatf("%s_valid[%0d]", tag, a), 128'(rk_valid), 128'(exp_v));
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a <= 10; a++) read_check(4'(a), exp_rk[a], 1'b1, tag);
    endtask

    // n = cycles already elapsed since the accepting edge.
    task automatic wait_done(input int n0, input string tag);
        int n;
        n = n0;
        while (!sched_done && n < 100) begin
            tick();
            n++;
        end
        check(tag, 128'(n), 128'd50);
    endtask

    task automatic handshake(input logic [127:0] key);
        key_valid = 1'b1;
        key_in    = key;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_key_ready"},  128'(key_ready),  128'd1);
        check({tag, "_busy"},       128'(busy),       128'd0);
        check({tag, "_sched_done"}, 128'(sched_done), 128'd0);
        check({tag, "_rk_data"},    rk_data,          128'd0);
        check({tag, "_rk_valid"},   128'(rk_valid),   128'd0);
    endtask

    initial begin
        logic [127:0] rkey;

        rst       = 1'b1;
        key_valid = 1'b0;
        key_in    = '0;
        rk_addr   = 4'd0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Known vector with key_valid held high and key_in changing throughout.
        model_expand(c_K1);
        key_valid = 1'b1;
        key_in    = c_K1;
        rk_addr   = 4'd0;
        tick();
        for (int c = 1; c <= 50; c++) begin
            key_in = {$urandom, $urandom, $urandom, $urandom};
            tick();
            if (c < 50) check($sformatf("hold_key_ready_c%0d", c), 128'(key_ready), 128'd0);
            if (c == 1) begin
                check("rd0_after_hs_data",  rk_data,          c_K1);
                check("rd0_after_hs_valid", 128'(rk_valid),   128'd1);
                check("busy_c1",            128'(busy),       128'd1);
                rk_addr = 4'd1;
            end
            if (c == 3) check("rd1_early_valid",   128'(rk_valid), 128'd0);
            if (c == 5) check("rd1_same_edge_valid", 128'(rk_valid), 128'd0);
            if (c == 6) begin
                check("rd1_ready_valid", 128'(rk_valid), 128'd1);
                check("rd1_ready_data",  rk_data,        c_K1_R1);
            end
            if (c == 49) begin
                check("done_c49", 128'(sched_done), 128'd0);
                check("busy_c49", 128'(busy),       128'd1);
            end
            if (c == 50) begin
                check("done_c50",      128'(sched_done), 128'd1);
                check("busy_c50",      128'(busy),       128'd0);
                check("key_ready_c50", 128'(key_ready),  128'd1);
                key_valid = 1'b0;
            end
        end
        read_all("k1");
        read_check(4'd10, c_K1_RA, 1'b1, "k1_const");
        for (int a = 11; a <= 15; a++) read_check(4'(a), 128'd0, 1'b0, "oob");

        // Re-key while DONE.
        model_expand(c_K2);
        rk_addr = 4'd10;
        handshake(c_K2);
        check("rekey_done_drop",  128'(sched_done), 128'd0);
        check("rekey_key_ready",  128'(key_ready),  128'd0);
        tick();
        check("rekey_stale_valid", 128'(rk_valid), 128'd0);
        wait_done(1, "rekey_latency");
        read_check(4'd10, c_K2_RA, 1'b1, "k2_const");
        read_all("k2");

        // Random keys.
        for (int i = 0; i < 2; i++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            model_expand(rkey);
            handshake(rkey);
            wait_done(0, $sformatf("rand%0d_latency", i));
            read_all($sformatf("rand%0d", i));
        end

        // Asynchronous reset in the middle of an expansion.
        rkey = {$urandom, $urandom, $urandom, $urandom};
        rk_addr = 4'd0;
        handshake(rkey);
        for (int c = 1; c <= 20; c++) tick();
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #2;
        rst = 1'b0;
        tick();
        read_check(4'd0, 128'd0, 1'b0, "post_rst");
        read_check(4'd5, 128'd0, 1'b0, "post_rst");
        rkey = {$urandom, $urandom, $urandom, $urandom};
        model_expand(rkey);
        handshake(rkey);
        wait_done(0, "post_rst_latency");
        read_all("post_rst_key");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
